// File: rtl/key_entry.sv
// Keyboard key-entry stage: pops keys from the upstream buffer and edits a BCD entry register.
// Optional KEY_ENTRY_HEX_EN: accept 'A'-'F' / 'a'-'f' as hex digits 0xA..0xF.
module key_entry #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  interrupt,
    input  logic [7:0]            ascii_code,
    output logic                  DoRead,
    output logic [4*DIGITS-1:0]   edit_bcd,
    output logic [2:0]            digit_count,
    output logic [4*DIGITS-1:0]   entry_bcd,
    output logic                  entry_valid,
    output logic                  overflow
);

    localparam int unsigned W         = 4 * DIGITS;
    localparam logic [2:0]  MAX_COUNT = 3'(DIGITS);

    localparam logic [7:0] KEY_BS    = 8'h08;
    localparam logic [7:0] KEY_ESC   = 8'h1B;
    localparam logic [7:0] KEY_ENTER = 8'h0D;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SETTLE,
        EXEC
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [7:0]     key_reg;
    logic [7:0]     key_nxt;
    logic           do_read_nxt;
    logic [W-1:0]   edit_nxt;
    logic [2:0]     count_nxt;
    logic [W-1:0]   entry_nxt;
    logic           valid_nxt;
    logic           ovf_nxt;

    logic           is_digit_c;
    logic [3:0]     nibble_c;

    // Classify the latched key as a digit and produce its nibble value
    always_comb begin
        is_digit_c = 1'b0;
        nibble_c   = key_reg[3:0];
        if (key_reg >= 8'h30 && key_reg <= 8'h39) begin
            is_digit_c = 1'b1;
        end
`ifdef KEY_ENTRY_HEX_EN
        else if ((key_reg >= 8'h41 && key_reg <= 8'h46) ||
                 (key_reg >= 8'h61 && key_reg <= 8'h66)) begin
            is_digit_c = 1'b1;
            nibble_c   = key_reg[3:0] + 4'd9;
        end
`endif
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state;
        key_nxt     = key_reg;
        do_read_nxt = 1'b0;
        edit_nxt    = edit_bcd;
        count_nxt   = digit_count;
        entry_nxt   = entry_bcd;
        valid_nxt   = 1'b0;
        ovf_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (interrupt) begin
                    key_nxt     = ascii_code;
                    do_read_nxt = 1'b1;
                    state_nxt   = READ;
                end
            end
            READ: begin
                state_nxt = SETTLE;
            end
            SETTLE: begin
                state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt = IDLE;
                if (is_digit_c) begin
                    if (digit_count < MAX_COUNT) begin
                        edit_nxt  = (edit_bcd << 4) | W'(nibble_c);
                        count_nxt = digit_count + 3'd1;
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                end else begin
                    case (key_reg)
                        KEY_BS: begin
                            if (digit_count != 3'd0) begin
                                edit_nxt  = edit_bcd >> 4;
                                count_nxt = digit_count - 3'd1;
                            end
                        end
                        KEY_ESC: begin
                            edit_nxt  = '0;
                            count_nxt = 3'd0;
                        end
                        KEY_ENTER: begin
                            if (digit_count != 3'd0) begin
                                entry_nxt = edit_bcd;
                                valid_nxt = 1'b1;
                                edit_nxt  = '0;
                                count_nxt = 3'd0;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset discards any latched key
    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= IDLE;
            key_reg     <= 8'h00;
            DoRead      <= 1'b0;
            edit_bcd    <= '0;
            digit_count <= 3'd0;
            entry_bcd   <= '0;
            entry_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_nxt;
            key_reg     <= key_nxt;
            DoRead      <= do_read_nxt;
            edit_bcd    <= edit_nxt;
            digit_count <= count_nxt;
            entry_bcd   <= entry_nxt;
            entry_valid <= valid_nxt;
            overflow    <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_key_entry.sv
// Self-checking bench for key_entry: directed key sequences plus random keys against a digit-list model.
module tb_key_entry;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic           clk = 1'b0;
    logic           Reset;
    logic           interrupt;
    logic [7:0]     ascii_code;
    logic           DoRead;
    logic [W-1:0]   edit_bcd;
    logic [2:0]     digit_count;
    logic [W-1:0]   entry_bcd;
    logic           entry_valid;
    logic           overflow;

    always #5 clk = ~clk;

    key_entry #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .interrupt  (interrupt),
        .ascii_code (ascii_code),
        .DoRead     (DoRead),
        .edit_bcd   (edit_bcd),
        .digit_count(digit_count),
        .entry_bcd  (entry_bcd),
        .entry_valid(entry_valid),
        .overflow   (overflow)
    );

    // Upstream key buffer: non-empty drives interrupt, popped on DoRead
    logic [7:0] fifo [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int cyc    = 0;
    int pulses = 0;

    assign interrupt  = (wr_ptr != rd_ptr);
    assign ascii_code = fifo[rd_ptr % 64];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (DoRead) begin
            pulses <= pulses + 1;
            if (wr_ptr != rd_ptr) rd_ptr <= rd_ptr + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: list of typed digit values (oldest first) and last committed value
    int          m_digits[$];
    logic [31:0] m_entry = 0;

    function automatic int key_value(input logic [7:0] k);
        if (k >= 8'h30 && k <= 8'h39) return int'(k) - 48;
`ifdef KEY_ENTRY_HEX_EN
        if (k >= 8'h41 && k <= 8'h46) return int'(k) - 55;
        if (k >= 8'h61 && k <= 8'h66) return int'(k) - 87;
`endif
        return -1;
    endfunction

    function automatic logic [31:0] model_edit();
        logic [31:0] v = 0;
        foreach (m_digits[i]) v = v * 16 + 32'(m_digits[i]);
        return v;
    endfunction

    task automatic model_apply(input logic [7:0] k, output logic ev, output logic eo);
        int d;
        ev = 1'b0;
        eo = 1'b0;
        d  = key_value(k);
        if (d >= 0) begin
            if (m_digits.size() < DIGITS) m_digits.push_back(d);
            else eo = 1'b1;
        end else if (k == 8'h08) begin
            if (m_digits.size() > 0) void'(m_digits.pop_back());
        end else if (k == 8'h1B) begin
            m_digits.delete();
        end else if (k == 8'h0D) begin
            if (m_digits.size() > 0) begin
                m_entry = model_edit();
                ev = 1'b1;
                m_digits.delete();
            end
        end
    endtask

    task automatic push(input logic [7:0] k);
        fifo[wr_ptr % 64] = k;
        wr_ptr++;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_edit"},  32'(edit_bcd),    model_edit());
        check({tag, "_count"}, 32'(digit_count), 32'(m_digits.size()));
        check({tag, "_entry"}, 32'(entry_bcd),   m_entry);
    endtask

    // Push one key, follow it through pop/settle/exec and check the result and strobes
    task automatic send_key(input logic [7:0] k);
        int   waited;
        logic ev, eo;
        push(k);
        waited = 0;
        while (!DoRead && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!DoRead) begin
            check("pop_timeout", 32'(0), 32'(1));
            return;
        end
        check("pop_latency", 32'(waited), 32'(1));
        @(negedge clk);
        check("doread_width", 32'(DoRead), 32'(0));
        @(negedge clk);
        @(negedge clk);
        model_apply(k, ev, eo);
        check_state("exec");
        check("entry_valid", 32'(entry_valid), 32'(ev));
        check("overflow",    32'(overflow),    32'(eo));
        @(negedge clk);
        check("valid_drop", 32'(entry_valid), 32'(0));
        check("ovf_drop",   32'(overflow),    32'(0));
    endtask

    logic [7:0] pool [0:19] = '{8'h30, 8'h31, 8'h32, 8'h35, 8'h37, 8'h39, 8'h08, 8'h1B,
                                8'h0D, 8'h0D, 8'h00, 8'h41, 8'h46, 8'h61, 8'h66, 8'h47,
                                8'h2F, 8'h3A, 8'h34, 8'h08};

    initial begin
        int          p0;
        int          times[$];
        logic [31:0] exp_hex;
        logic        ev, eo;

        Reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_doread", 32'(DoRead), 32'(0));
        check_state("rst");
        check("rst_valid", 32'(entry_valid), 32'(0));
        check("rst_ovf",   32'(overflow),    32'(0));
        Reset = 1'b0;
        @(negedge clk);

        // '1','2','3',Enter commits 0x0123 with four pops
        p0 = pulses;
        send_key(8'h31);
        send_key(8'h32);
        send_key(8'h33);
        send_key(8'h0D);
        check("commit_0123", 32'(entry_bcd), 32'h0123);
        check("four_pops", 32'(pulses - p0), 32'(4));

        // Fifth digit overflows
        send_key(8'h39);
        send_key(8'h38);
        send_key(8'h37);
        send_key(8'h36);
        send_key(8'h35);
        check("full_9876", 32'(edit_bcd), 32'h9876);

        // Backspace editing, then backspace at empty buffer
        send_key(8'h1B);
        send_key(8'h34);
        send_key(8'h32);
        send_key(8'h08);
        send_key(8'h37);
        send_key(8'h0D);
        check("commit_0047", 32'(entry_bcd), 32'h0047);
        p0 = pulses;
        send_key(8'h08);
        check("bs_empty_pop", 32'(pulses - p0), 32'(1));

        // Escape then Enter: no commit
        send_key(8'h35);
        send_key(8'h1B);
        send_key(8'h0D);
        check("esc_keeps", 32'(entry_bcd), 32'h0047);

        // Hex letters
        send_key(8'h61);
        send_key(8'h46);
        send_key(8'h0D);
`ifdef KEY_ENTRY_HEX_EN
        exp_hex = 32'h00AF;
`else
        exp_hex = 32'h0047;
`endif
        check("hex_entry", 32'(entry_bcd), exp_hex);

        // interrupt held high with three queued keys
        send_key(8'h1B);
        push(8'h31);
        push(8'h32);
        push(8'h33);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (DoRead) times.push_back(cyc);
        end
        check("held_pulses", 32'(times.size()), 32'(3));
        if (times.size() == 3) begin
            check("held_gap1", 32'(times[1] - times[0]), 32'(4));
            check("held_gap2", 32'(times[2] - times[1]), 32'(4));
        end
        model_apply(8'h31, ev, eo);
        model_apply(8'h32, ev, eo);
        model_apply(8'h33, ev, eo);
        check_state("held");
        check("held_0123", 32'(edit_bcd), 32'h0123);

        // Reset while in READ discards the latched key
        send_key(8'h37);
        push(8'h35);
        for (int i = 0; i < 8 && !DoRead; i++) @(negedge clk);
        check("rst_read_seen", 32'(DoRead), 32'(1));
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        m_digits.delete();
        m_entry = 0;
        check("rst_read_doread", 32'(DoRead), 32'(0));
        check_state("rst_read");
        p0 = pulses;
        repeat (6) @(negedge clk);
        check("rst_read_idle", 32'(pulses - p0), 32'(0));
        check_state("rst_read_after");

        // Random keys
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) send_key(8'($urandom()));
            else send_key(pool[$urandom_range(0, 19)]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
